// File: rtl/mem_acc_pkg.sv
// Shared encodings, FSM state type and alignment helper for the data-memory
// load/store controller.
package mem_acc_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_RSVD = 2'b11;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ACCESS = 3'd1,
        WRITE  = 3'd2,
        ERR    = 3'd3,
        RESP   = 3'd4
    } state_t;

    // Reserved size is folded in here so the accept path has a single check.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        logic bad;
        bad = 1'b0;
        case (size)
            SZ_BYTE: bad = 1'b0;
            SZ_HALF: bad = addr_lo[0];
            SZ_WORD: bad = |addr_lo;
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/byte_lane_unit.sv
// Little-endian lane extraction/extension for loads and lane merge for
// sub-word stores; purely combinational.
module byte_lane_unit
    import mem_acc_pkg::*;
(
    input  logic [31:0] i_word,
    input  logic [1:0]  i_addr_lo,
    input  logic [1:0]  i_size,
    input  logic        i_sext,
    input  logic [15:0] i_wdata,
    output logic [31:0] o_load,
    output logic [31:0] o_merged
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte = i_word[7:0];
        case (i_addr_lo)
            2'd1:    w_byte = i_word[15:8];
            2'd2:    w_byte = i_word[23:16];
            2'd3:    w_byte = i_word[31:24];
            default: w_byte = i_word[7:0];
        endcase
        w_half = i_addr_lo[1] ? i_word[31:16] : i_word[15:0];

        // Word loads ignore sext.
        o_load = i_word;
        if (i_size == SZ_BYTE) begin
            o_load = {{24{i_sext & w_byte[7]}}, w_byte};
        end else if (i_size == SZ_HALF) begin
            o_load = {{16{i_sext & w_half[15]}}, w_half};
        end

        o_merged = i_word;
        if (i_size == SZ_BYTE) begin
            case (i_addr_lo)
                2'd1:    o_merged[15:8]  = i_wdata[7:0];
                2'd2:    o_merged[23:16] = i_wdata[7:0];
                2'd3:    o_merged[31:24] = i_wdata[7:0];
                default: o_merged[7:0]   = i_wdata[7:0];
            endcase
        end else if (i_size == SZ_HALF) begin
            if (i_addr_lo[1]) begin
                o_merged[31:16] = i_wdata;
            end else begin
                o_merged[15:0] = i_wdata;
            end
        end
    end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store controller between the pipeline and word-addressed data memory:
// one request at a time, sub-word stores done as read-modify-write.
module mem_access_unit
    import mem_acc_pkg::*;
#(
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req,
    input  logic              wr,
    input  logic [1:0]        size,
    input  logic              sext,
    input  logic [31:0]       addr,
    input  logic [31:0]       wdata,
    output logic              busy,
    output logic              done,
    output logic [31:0]       rdata,
    output logic              exc_adel,
    output logic              exc_ades,
    output logic [ADDR_W-3:0] mem_addr,
    output logic [31:0]       mem_din,
    output logic              mem_we,
    input  logic [31:0]       mem_dout
);

    state_t              r_state;
    state_t              w_next;
    logic                r_wr;
    logic [1:0]          r_size;
    logic                r_sext;
    logic [ADDR_W-1:0]   r_addr;
    logic [31:0]         r_wdata;
    logic [31:0]         r_rdata;
    logic [31:0]         r_merged;
    logic                r_exc_adel;
    logic                r_exc_ades;
    logic                w_bad;
    logic                w_word_store;
    logic [31:0]         w_load;
    logic [31:0]         w_merged;

    assign w_bad        = is_misaligned(size, addr[1:0]) | (|addr[31:ADDR_W]);
    assign w_word_store = r_wr && (r_size == SZ_WORD);

    byte_lane_unit u_lanes (
        .i_word    (mem_dout),
        .i_addr_lo (r_addr[1:0]),
        .i_size    (r_size),
        .i_sext    (r_sext),
        .i_wdata   (r_wdata[15:0]),
        .o_load    (w_load),
        .o_merged  (w_merged)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next  = r_state;
        mem_we  = 1'b0;
        mem_din = 32'd0;
        case (r_state)
            IDLE: begin
                if (req) begin
                    w_next = w_bad ? ERR : ACCESS;
                end
            end
            ACCESS: begin
                if (w_word_store) begin
                    mem_we  = 1'b1;
                    mem_din = r_wdata;
                end
                w_next = (r_wr && !w_word_store) ? WRITE : RESP;
            end
            WRITE: begin
                mem_we  = 1'b1;
                mem_din = r_merged;
                w_next  = RESP;
            end
            ERR:     w_next = RESP;
            RESP:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
        // A reset landing on the write edge must not let the store through.
        if (reset) begin
            mem_we  = 1'b0;
            mem_din = 32'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr       <= 1'b0;
            r_size     <= SZ_BYTE;
            r_sext     <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= 32'd0;
            r_rdata    <= 32'd0;
            r_merged   <= 32'd0;
            r_exc_adel <= 1'b0;
            r_exc_ades <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (req) begin
                        r_wr       <= wr;
                        r_size     <= size;
                        r_sext     <= sext;
                        r_addr     <= addr[ADDR_W-1:0];
                        r_wdata    <= wdata;
                        r_exc_adel <= 1'b0;
                        r_exc_ades <= 1'b0;
                    end
                end
                ACCESS: begin
                    if (!r_wr) begin
                        r_rdata <= w_load;
                    end else begin
                        r_merged <= w_merged;
                    end
                end
                ERR: begin
                    r_exc_adel <= ~r_wr;
                    r_exc_ades <= r_wr;
                end
                default: ;
            endcase
        end
    end

    assign busy     = (r_state != IDLE);
    assign done     = (r_state == RESP);
    assign rdata    = r_rdata;
    assign exc_adel = r_exc_adel;
    assign exc_ades = r_exc_ades;
    assign mem_addr = r_addr[ADDR_W-1:2];

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a behavioural 4 KB data memory.
module tb_mem_access_unit;

    localparam int ADDR_W = 12;

    logic              clk;
    logic              reset;
    logic              req;
    logic              wr;
    logic [1:0]        size;
    logic              sext;
    logic [31:0]       addr;
    logic [31:0]       wdata;
    logic              busy;
    logic              done;
    logic [31:0]       rdata;
    logic              exc_adel;
    logic              exc_ades;
    logic [ADDR_W-3:0] mem_addr;
    logic [31:0]       mem_din;
    logic              mem_we;
    logic [31:0]       mem_dout;

    logic [31:0] mem [0:(1<<(ADDR_W-2))-1];
    int          we_count;
    int          done_count;
    logic [31:0] last_we_addr;
    logic [31:0] last_we_data;
    int          n_checks;
    int          n_fail;

    mem_access_unit #(.ADDR_W(ADDR_W)) dut (
        .clk      (clk),
        .reset    (reset),
        .req      (req),
        .wr       (wr),
        .size     (size),
        .sext     (sext),
        .addr     (addr),
        .wdata    (wdata),
        .busy     (busy),
        .done     (done),
        .rdata    (rdata),
        .exc_adel (exc_adel),
        .exc_ades (exc_ades),
        .mem_addr (mem_addr),
        .mem_din  (mem_din),
        .mem_we   (mem_we),
        .mem_dout (mem_dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign mem_dout = mem[mem_addr];

    always @(posedge clk) begin
        if (mem_we) begin
            mem[mem_addr] <= mem_din;
            we_count      <= we_count + 1;
            last_we_addr  <= 32'(mem_addr);
            last_we_data  <= mem_din;
        end
        if (done) done_count <= done_count + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Starts a request from an IDLE cycle and returns in the done cycle;
    // lat counts edges from the accept edge to the edge sampling done high.
    task automatic do_op(input logic w, input logic [1:0] sz, input logic sx,
                         input logic [31:0] a, input logic [31:0] wd, output int lat);
        req = 1'b1; wr = w; size = sz; sext = sx; addr = a; wdata = wd;
        @(posedge clk); #1;
        req = 1'b0;
        lat = 1;
        while (!done && lat < 10) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic step;
        @(posedge clk); #1;
    endtask

    initial begin
        int lat;
        int we0;
        int dn0;
        n_checks = 0; n_fail = 0; we_count = 0; done_count = 0;
        last_we_addr = 0; last_we_data = 0;
        for (int i = 0; i < (1 << (ADDR_W-2)); i++) mem[i] = 32'd0;
        reset = 1'b1; req = 1'b0; wr = 1'b0; size = 2'b00; sext = 1'b0;
        addr = 32'd0; wdata = 32'd0;
        step; step;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_we", 32'(mem_we), 32'd0);
        check("rst_rdata", rdata, 32'd0);
        check("rst_adel", 32'(exc_adel), 32'd0);
        check("rst_ades", 32'(exc_ades), 32'd0);
        check("rst_maddr", 32'(mem_addr), 32'd0);
        check("rst_mdin", mem_din, 32'd0);
        reset = 1'b0;
        step;

        // Word store then word load
        we0 = we_count;
        do_op(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, lat);
        check("sw_lat", 32'(lat), 32'd2);
        check("sw_ades", 32'(exc_ades), 32'd0);
        check("sw_we_cnt", 32'(we_count - we0), 32'd1);
        check("sw_we_addr", last_we_addr, 32'd4);
        check("sw_we_data", last_we_data, 32'hDEADBEEF);
        step;
        we0 = we_count;
        do_op(1'b0, 2'b10, 1'b1, 32'h10, 32'h0, lat);
        check("lw_lat", 32'(lat), 32'd2);
        check("lw_rdata", rdata, 32'hDEADBEEF);
        check("lw_adel", 32'(exc_adel), 32'd0);
        step;
        check("lw_rdata_held", rdata, 32'hDEADBEEF);
        check("lw_no_we", 32'(we_count - we0), 32'd0);

        // Sub-word loads with extension
        do_op(1'b0, 2'b00, 1'b1, 32'h13, 32'h0, lat);
        check("lb_lat", 32'(lat), 32'd2);
        check("lb_rdata", rdata, 32'hFFFFFFDE);
        step;
        do_op(1'b0, 2'b00, 1'b0, 32'h13, 32'h0, lat);
        check("lbu_rdata", rdata, 32'h000000DE);
        step;
        do_op(1'b0, 2'b01, 1'b1, 32'h10, 32'h0, lat);
        check("lh_lat", 32'(lat), 32'd2);
        check("lh_rdata", rdata, 32'hFFFFBEEF);
        step;
        do_op(1'b0, 2'b01, 1'b0, 32'h12, 32'h0, lat);
        check("lhu_rdata", rdata, 32'h0000DEAD);
        step;

        // Sub-word stores (read-modify-write)
        we0 = we_count;
        do_op(1'b1, 2'b00, 1'b0, 32'h11, 32'h12345677, lat);
        check("sb_lat", 32'(lat), 32'd3);
        check("sb_word", mem[4], 32'hDEAD77EF);
        check("sb_we_cnt", 32'(we_count - we0), 32'd1);
        step;
        we0 = we_count;
        do_op(1'b1, 2'b01, 1'b0, 32'h12, 32'hAAAA5555, lat);
        check("sh_lat", 32'(lat), 32'd3);
        check("sh_word", mem[4], 32'h555577EF);
        check("sh_we_cnt", 32'(we_count - we0), 32'd1);
        step;

        // Address errors
        we0 = we_count;
        do_op(1'b0, 2'b10, 1'b0, 32'h12, 32'h0, lat);
        check("lw_mis_lat", 32'(lat), 32'd2);
        check("lw_mis_adel", 32'(exc_adel), 32'd1);
        check("lw_mis_ades", 32'(exc_ades), 32'd0);
        check("lw_mis_rdata", rdata, 32'h0000DEAD);
        step;
        do_op(1'b1, 2'b01, 1'b0, 32'h13, 32'hFFFFFFFF, lat);
        check("sh_mis_lat", 32'(lat), 32'd2);
        check("sh_mis_ades", 32'(exc_ades), 32'd1);
        check("sh_mis_adel", 32'(exc_adel), 32'd0);
        step;
        do_op(1'b1, 2'b10, 1'b0, 32'h1000, 32'hFFFFFFFF, lat);
        check("sw_oor_lat", 32'(lat), 32'd2);
        check("sw_oor_ades", 32'(exc_ades), 32'd1);
        step;
        do_op(1'b0, 2'b11, 1'b0, 32'h0, 32'h0, lat);
        check("rsvd_adel", 32'(exc_adel), 32'd1);
        step;
        check("err_no_we", 32'(we_count - we0), 32'd0);
        check("err_mem", mem[4], 32'h555577EF);
        check("err_mem0", mem[0], 32'h0);
        do_op(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, lat);
        check("exc_clear", 32'(exc_adel), 32'd0);
        check("lw_after_err", rdata, 32'h555577EF);
        step;

        // Reset during the WRITE cycle of a byte store
        mem[8] = 32'h11111111;
        we0 = we_count;
        req = 1'b1; wr = 1'b1; size = 2'b00; sext = 1'b0; addr = 32'h20; wdata = 32'hFF;
        step;
        req = 1'b0;
        step;
        check("rmw_in_write", 32'(mem_we), 32'd1);
        reset = 1'b1;
        #1;
        check("rmw_we_gated", 32'(mem_we), 32'd0);
        @(posedge clk); #1;
        check("rmw_rst_we", 32'(we_count - we0), 32'd0);
        check("rmw_rst_mem", mem[8], 32'h11111111);
        check("rmw_rst_busy", 32'(busy), 32'd0);
        check("rmw_rst_done", 32'(done), 32'd0);
        check("rmw_rst_rdata", rdata, 32'd0);
        check("rmw_rst_maddr", 32'(mem_addr), 32'd0);
        reset = 1'b0;
        step;
        check("rmw_post_we", 32'(we_count - we0), 32'd0);
        do_op(1'b0, 2'b10, 1'b0, 32'h20, 32'h0, lat);
        check("rmw_lw", rdata, 32'h11111111);
        step;

        // req held high across a busy load
        mem[4] = 32'hDEADBEEF;
        mem[5] = 32'hCAFEF00D;
        dn0 = done_count;
        req = 1'b1; wr = 1'b0; size = 2'b10; sext = 1'b0; addr = 32'h10;
        step;
        addr = 32'h14;
        check("hold_busy1", 32'(busy), 32'd1);
        step;
        check("hold_done1", 32'(done), 32'd1);
        check("hold_rdata1", rdata, 32'hDEADBEEF);
        step;
        check("hold_idle", 32'(busy), 32'd0);
        step;
        req = 1'b0;
        check("hold_busy2", 32'(busy), 32'd1);
        step;
        check("hold_done2", 32'(done), 32'd1);
        check("hold_rdata2", rdata, 32'hCAFEF00D);
        step; step;
        check("hold_done_cnt", 32'(done_count - dn0), 32'd2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Initiator-side load/store controller for the MIPS datapath; sits between the execute/memory stage and the word-addressed 4 KB data memory.
- Turns byte/halfword/word load and store requests into word accesses: lane extraction and sign/zero extension for loads, read-modify-write for sub-word stores.
- Detects misaligned and out-of-range addresses and reports them as exceptions, not memory accesses.
- Single request outstanding; req/busy/done handshake towards the pipeline.

Parameters:
- ADDR_W, 12, byte-address width of data memory; valid addresses are 0 .. 2^ADDR_W-1.

Ports:
- clk  in  1  system clock, all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- req  in  1  request strobe; sampled only when busy=0
- wr  in  1  1=store, 0=load
- size  in  2  00 byte, 01 halfword, 10 word, 11 reserved
- sext  in  1  loads only: 1=sign-extend, 0=zero-extend
- addr  in  32  byte address
- wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0])
- busy  out  1  high from accept cycle+1 until done cycle inclusive
- done  out  1  one-cycle completion pulse
- rdata  out  32  extended load result; valid from done, held until next accept
- exc_adel  out  1  load address error, valid with done
- exc_ades  out  1  store address error, valid with done
- mem_addr  out  ADDR_W-2  word address to data memory
- mem_din  out  32  write data to data memory
- mem_we  out  1  memory write enable; memory writes on the clk edge where it is high
- mem_dout  in  32  combinational read data from memory at mem_addr

Behaviour:
- Reset: state IDLE; busy=0, done=0, mem_we=0, rdata=0, exc_adel=0, exc_ades=0, mem_addr=0, mem_din=0.
- Reset has priority over everything. Reset during any state aborts to IDLE. No mem_we is driven in the cycle after the reset edge. A partially completed RMW leaves memory unmodified.
- Accept: IDLE && req → latch wr, size, sext, addr, wdata, then go to ACCESS. req while busy=1 is ignored (not queued).
- Error check at accept:
  - halfword with addr[0]!=0
  - word with addr[1:0]!=0
  - size=11
  - addr[31:ADDR_W]!=0
  - Any of these → state ERR.
- ERR (1 cycle):
  - mem_we=0; no memory access.
  - Next cycle: RESP with exc_adel=~wr, exc_ades=wr.
  - rdata unchanged.
- ACCESS:
  - mem_addr=addr[ADDR_W-1:2].
  - Load: capture the lane from mem_dout into rdata, extended per sext; go to RESP.
  - Lanes are little-endian: byte k = mem_dout[8k+7:8k]; half at addr[1]=1 = mem_dout[31:16].
  - Word store: mem_we=1, mem_din=wdata; go to RESP.
  - Sub-word store: register merged word = mem_dout with the target lane(s) replaced by wdata[7:0] or wdata[15:0]; go to WRITE.
- WRITE: mem_we=1, mem_din=merged word, mem_addr held; go to RESP.
- RESP: done=1, busy=1; go to IDLE. A new req is accepted in the following IDLE cycle at the earliest.
- Latency, accept edge to done high:
  - lw/lb/lh/sw and errors: 2 cycles
  - sb/sh: 3 cycles
- mem_we is high for exactly one cycle per successful store and never for loads or errors.
- Exceptions clear to 0 at the next accept.
- sext is ignored for stores and for word loads.

Decomposition:
- Package mem_acc_pkg holds:
  - size encodings SZ_BYTE/SZ_HALF/SZ_WORD
  - state enum IDLE/ACCESS/WRITE/ERR/RESP
  - misalignment check function
- One combinational sub-module, byte_lane_unit: inputs word, addr[1:0], size, sext, wdata; outputs extracted/extended load value and merged store word. It is shared by the ACCESS load path and the RMW path.

Test Plan:
- sw addr=0x10 wdata=0xDEADBEEF, then lw 0x10 → mem_we pulses once with mem_addr=4, mem_din=0xDEADBEEF; lw done 2 cycles after accept, rdata=0xDEADBEEF.
- Word at 0x10 = 0xDEADBEEF; lb 0x13 sext=1 → rdata=0xFFFFFFDE; lbu 0x13 → 0x000000DE; lh 0x10 sext=1 → 0xFFFFBEEF; lhu 0x12 → 0x0000DEAD.
- Word at 0x10 = 0xDEADBEEF; sb 0x11 wdata=0x12345677 → done at 3 cycles, word=0xDEAD77EF; sh 0x12 wdata=0xAAAA5555 → word=0x555577EF.
- lw 0x12, sh 0x13, sw 0x1000 → no mem_we ever; done at 2 cycles. Flags: lw 0x12 exc_adel=1; sh 0x13 exc_ades=1; sw 0x1000 exc_ades=1. Memory unchanged.
- Word at 0x20 = 0x11111111; sb 0x20, reset asserted in WRITE cycle → no mem_we after reset; word stays 0x11111111; outputs at reset values; next lw 0x20 returns 0x11111111.
- req held high during a busy lw with a different addr → second request not accepted until IDLE; exactly one done per accepted request.
